regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  Register file for the project datapath: read side plus storage for the ALU operand registers.
//  Two synchronous read ports (A, B) and one write port. Read data is registered.
//  Write-to-read bypass is included, so the datapath sees the newest value of a register.
//  It sits between the instruction decode stage (which supplies the addresses) and the ALU operand inputs.
// PARAMETERS
//  DATA_WIDTH  32  width of each register word (signed)
//  ADDR_WIDTH  5   address width; depth = 2**ADDR_WIDTH words
//  ZERO_REG    1   1: register 0 is hard-wired to 0 (writes ignored); 0: register 0 is ordinary
// PORTS
//  Clk      in   1           single clock; every flop is on the rising edge
//  Reset    in   1           synchronous, active-high reset
//  Write    in   1           write enable for the write port
//  WrAddr   in   ADDR_WIDTH  write address
//  WrData   in   DATA_WIDTH  write data (signed)
//  RdEn     in   1           read request; samples RdAddrA and RdAddrB
//  RdAddrA  in   ADDR_WIDTH  port A read address
//  RdAddrB  in   ADDR_WIDTH  port B read address
//  RdDataA  out  DATA_WIDTH  port A read data (signed), registered
//  RdDataB  out  DATA_WIDTH  port B read data (signed), registered
//  RdValid  out  1           high for one cycle when RdDataA/B hold the result of a read
// BEHAVIOUR
//  - Reset (sampled at the edge) clears all words, RdDataA/B and RdValid to 0. Reset overrides Write and RdEn in that cycle.
//  - Write: if Write=1 at edge N, mem[WrAddr] <= WrData.
//    If ZERO_REG=1 and WrAddr=0, the write is dropped.
//  - Read latency is 1 cycle:
//    - RdEn=1 at edge N -> RdDataA/B and RdValid=1 are visible after edge N.
//    - RdEn=0 at edge N -> RdValid=0 and RdDataA/B hold their previous values.
//  - Bypass: a same-edge write and read to one address returns WrData, not the old value.
//    Applies per port independently. Never applies to reg 0 when ZERO_REG=1.
//  - ZERO_REG=1: a read of address 0 always returns 0.
//  - A and B may read the same address; both return the same value.
//  - RdValid is a pulse with no backpressure. Back-to-back RdEn gives back-to-back valid results.
//  - Reset mid-stream: a read requested in the reset cycle is discarded, so RdValid=0 on the next cycle.
//  - Out-of-range addresses cannot occur, because depth = 2**ADDR_WIDTH.
// STRUCTURE
//  - Shared package (regfile_pkg): DATA_WIDTH/ADDR_WIDTH defaults and the ZERO_ADDR constant.
//  - Sub-module regfile_bank holds the storage array. It has one write port and two combinational read muxes.
//  - The top level adds the bypass compare, the zero-register masking and the output/valid flops.
// TESTING
//  1. Reset=1 for 2 cycles, then RdEn with A=3, B=7 -> RdDataA=0, RdDataB=0, RdValid=1 one cycle later.
//  2. Write 5<=32'h1234_5678. Next cycle RdEn with A=5
//     -> RdDataA=32'h1234_5678 after 1 cycle.
//  3. Same edge: Write 9<=-1 and RdEn with A=9, B=9 (reg 9 old value 0)
//     -> RdDataA=RdDataB=32'hFFFF_FFFF (bypass).
//  4. ZERO_REG=1: write 0<=32'hDEAD_BEEF, then read A=0
//     -> RdDataA=0. With ZERO_REG=0, the same sequence returns 32'hDEAD_BEEF.
//  5. RdEn asserted 3 cycles back-to-back, then deasserted
//     -> RdValid=1,1,1,0 and the data holds after the last valid.
//  6. Reset during a stream: RdEn=1 with Reset=1 on the same edge
//     -> RdValid=0 next cycle; all previously written registers read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the 2-read/1-write register file.
package regfile_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int ZERO_ADDR          = 0;
endpackage

// File: rtl/regfile_bank.sv
// Storage array for the register file: one write port and two combinational read muxes.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]      wr_sel;
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    // One-hot write decode; the hard-wired zero register never gets selected.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = we && (wr_addr == ADDR_WIDTH'(gi))
                                && !((ZERO_REG != 0) && (gi == ZERO_ADDR));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= wr_data;
                end
            end
        end
    end

    assign rd_data_a = mem_reg[rd_addr_a];
    assign rd_data_b = mem_reg[rd_addr_b];
endmodule

// File: rtl/regfile_2r1w.sv
// Register file top: write-to-read bypass, zero-register masking and registered read outputs.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Write,
    input  logic [ADDR_WIDTH-1:0]        WrAddr,
    input  logic signed [DATA_WIDTH-1:0] WrData,
    input  logic                         RdEn,
    input  logic [ADDR_WIDTH-1:0]        RdAddrA,
    input  logic [ADDR_WIDTH-1:0]        RdAddrB,
    output logic signed [DATA_WIDTH-1:0] RdDataA,
    output logic signed [DATA_WIDTH-1:0] RdDataB,
    output logic                         RdValid
);
    logic [ADDR_WIDTH-1:0] rd_addr      [2];
    logic [DATA_WIDTH-1:0] bank_data    [2];
    logic [DATA_WIDTH-1:0] rd_data_next [2];
    logic [DATA_WIDTH-1:0] rd_data_reg  [2];
    logic                  rd_valid_reg;
    logic                  wr_is_zero;

    assign rd_addr[0] = RdAddrA;
    assign rd_addr[1] = RdAddrB;

    regfile_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_bank (
        .clk       (Clk),
        .srst      (Reset),
        .we        (Write),
        .wr_addr   (WrAddr),
        .wr_data   (WrData),
        .rd_addr_a (rd_addr[0]),
        .rd_addr_b (rd_addr[1]),
        .rd_data_a (bank_data[0]),
        .rd_data_b (bank_data[1])
    );

    assign wr_is_zero = (ZERO_REG != 0) && (WrAddr == ADDR_WIDTH'(ZERO_ADDR));

    // Per port: zero masking wins over bypass, bypass wins over stored data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic rd_is_zero;
            logic bypass;
            assign rd_is_zero = (ZERO_REG != 0) && (rd_addr[gi] == ADDR_WIDTH'(ZERO_ADDR));
            assign bypass     = Write && !wr_is_zero && (WrAddr == rd_addr[gi]);
            assign rd_data_next[gi] = rd_is_zero ? '0 :
                                      bypass     ? WrData : bank_data[gi];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_data_reg[0] <= '0;
            rd_data_reg[1] <= '0;
            rd_valid_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= RdEn;
            if (RdEn) begin
                rd_data_reg[0] <= rd_data_next[0];
                rd_data_reg[1] <= rd_data_next[1];
            end
        end
    end

    assign RdDataA = rd_data_reg[0];
    assign RdDataB = rd_data_reg[1];
    assign RdValid = rd_valid_reg;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed steps then random traffic, both ZERO_REG settings side by side.
module tb_regfile_2r1w;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 Write = 1'b0;
    logic [AW-1:0]        WrAddr = '0;
    logic signed [DW-1:0] WrData = '0;
    logic                 RdEn = 1'b0;
    logic [AW-1:0]        RdAddrA = '0;
    logic [AW-1:0]        RdAddrB = '0;

    logic signed [DW-1:0] rd_a [2];
    logic signed [DW-1:0] rd_b [2];
    logic                 rd_v [2];

    int compared = 0;
    int mismatched = 0;

    // Reference: instance 0 has a hard-wired zero register, instance 1 does not.
    logic [DW-1:0] ref_mem [2][DEPTH];
    logic [DW-1:0] ref_a [2];
    logic [DW-1:0] ref_b [2];
    logic          ref_v;
    bit            zero_reg [2] = '{1'b1, 1'b0};

    always #5 Clk = ~Clk;

    regfile_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_z (
        .Clk(Clk), .Reset(Reset), .Write(Write), .WrAddr(WrAddr), .WrData(WrData),
        .RdEn(RdEn), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
        .RdDataA(rd_a[0]), .RdDataB(rd_b[0]), .RdValid(rd_v[0])
    );

    regfile_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_n (
        .Clk(Clk), .Reset(Reset), .Write(Write), .WrAddr(WrAddr), .WrData(WrData),
        .RdEn(RdEn), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
        .RdDataA(rd_a[1]), .RdDataB(rd_b[1]), .RdValid(rd_v[1])
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference semantics: a write lands first, so a same-edge read sees the newest value.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = '0;
                ref_a[k] = '0;
                ref_b[k] = '0;
            end else begin
                if (Write && !(zero_reg[k] && WrAddr == 0)) ref_mem[k][WrAddr] = WrData;
                if (RdEn) begin
                    ref_a[k] = (zero_reg[k] && RdAddrA == 0) ? '0 : ref_mem[k][RdAddrA];
                    ref_b[k] = (zero_reg[k] && RdAddrB == 0) ? '0 : ref_mem[k][RdAddrB];
                end
            end
        end
        ref_v = !Reset && RdEn;
    endtask

    task automatic step(input bit rst, input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit re, input int ra, input int rb);
        Reset   = rst;
        Write   = we;
        WrAddr  = AW'(wa);
        WrData  = wd;
        RdEn    = re;
        RdAddrA = AW'(ra);
        RdAddrB = AW'(rb);
        @(posedge Clk);
        model_edge();
        #1;
        $display("t=%0t rst=%0b we=%0b wa=%0d wd=%h re=%0b ra=%0d rb=%0d | z: v=%0b a=%h b=%h | n: v=%0b a=%h b=%h",
                 $time, rst, we, wa, wd, re, ra, rb,
                 rd_v[0], rd_a[0], rd_b[0], rd_v[1], rd_a[1], rd_b[1]);
        chk("valid_z", {31'b0, rd_v[0]}, {31'b0, ref_v});
        chk("valid_n", {31'b0, rd_v[1]}, {31'b0, ref_v});
        chk("data_a_z", rd_a[0], ref_a[0]);
        chk("data_b_z", rd_b[0], ref_b[0]);
        chk("data_a_n", rd_a[1], ref_a[1]);
        chk("data_b_n", rd_b[1], ref_b[1]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = '0;
            ref_a[k] = '0;
            ref_b[k] = '0;
        end
        ref_v = 1'b0;

        // Reset for two cycles, then a read of fresh registers.
        step(1, 0, 0, '0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        step(0, 0, 0, '0, 1, 3, 7);
        chk("t1_a_zero", rd_a[0], 32'h0);
        chk("t1_valid", {31'b0, rd_v[0]}, 32'h1);

        // Write then read back.
        step(0, 1, 5, 32'h1234_5678, 0, 0, 0);
        step(0, 0, 0, '0, 1, 5, 5);
        chk("t2_a", rd_a[0], 32'h1234_5678);

        // Same-edge write and read of one register on both ports.
        step(0, 1, 9, 32'hFFFF_FFFF, 1, 9, 9);
        chk("t3_bypass_a", rd_a[0], 32'hFFFF_FFFF);
        chk("t3_bypass_b", rd_b[0], 32'hFFFF_FFFF);

        // Register 0: masked on dut_z, ordinary on dut_n (also try bypass to reg 0).
        step(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, 0, 0, '0, 1, 0, 5);
        chk("t4_zero_z", rd_a[0], 32'h0);
        chk("t4_zero_n", rd_a[1], 32'hDEAD_BEEF);
        step(0, 1, 0, 32'h0BAD_F00D, 1, 0, 0);
        chk("t4_byp_zero_z", rd_b[0], 32'h0);
        chk("t4_byp_zero_n", rd_b[1], 32'h0BAD_F00D);

        // Back-to-back reads, then idle: valid 1,1,1,0 and data holds.
        step(0, 0, 0, '0, 1, 5, 9);
        step(0, 1, 12, 32'h0000_00C0, 1, 12, 5);
        step(0, 0, 0, '0, 1, 9, 12);
        step(0, 1, 9, 32'h5555_AAAA, 0, 5, 5);
        chk("t5_hold_a", rd_a[0], 32'hFFFF_FFFF);
        chk("t5_hold_b", rd_b[0], 32'h0000_00C0);

        // Reset with a read request on the same edge: read discarded, contents cleared.
        step(1, 1, 7, 32'h7777_7777, 1, 5, 9);
        chk("t6_valid", {31'b0, rd_v[1]}, 32'h0);
        step(0, 0, 0, '0, 1, 5, 9);
        chk("t6_cleared_a", rd_a[1], 32'h0);
        step(0, 0, 0, '0, 1, 7, 0);

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0),
                 $urandom_range(0, 1),
                 int'($urandom_range(0, DEPTH - 1)),
                 $urandom,
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, DEPTH - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
